// File: rtl/lc4_alu_pkg.sv
// lc4_alu_pkg -- shared definitions for the sequencing wrapper around the LC4 ALU.
//
// Contents:
//   - op-code constants for the ALU control bus (0..39)
//   - state_e: wrapper FSM states
//   - is_legal_op(): true for any control code the ALU output mux decodes
//   - is_div_op():   true for the two ops served by the iterative divider
package lc4_alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 6;

  // Op codes referenced by the wrapper; every other legal code is passed
  // straight through to the shared single-cycle ALU.
  localparam logic [OP_W-1:0] OP_ADD = 6'd0;
  localparam logic [OP_W-1:0] OP_MUL = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB = 6'd2;
  localparam logic [OP_W-1:0] OP_DIV = 6'd3;
  localparam logic [OP_W-1:0] OP_MOD = 6'd4;
  localparam logic [OP_W-1:0] OP_BR  = 6'd39;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Holes in the output-mux encoding: 8, 13-15, 20-23, 27-31 and above BR.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal;
    legal = 1'b1;
    if (op > OP_BR)
      legal = 1'b0;
    else if (op == 6'd8)
      legal = 1'b0;
    else if ((op >= 6'd13) && (op <= 6'd15))
      legal = 1'b0;
    else if ((op >= 6'd20) && (op <= 6'd23))
      legal = 1'b0;
    else if ((op >= 6'd27) && (op <= 6'd31))
      legal = 1'b0;
    return legal;
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/lc4_div_iter.sv
// lc4_div_iter -- unsigned restoring divider, one quotient bit per cycle, MSB first.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 load dividend/divisor and begin (ignored while running)
//   dividend, divisor     16-bit unsigned operands, sampled on start
//   done                  high for one cycle during the final step; quotient and
//                         remainder are valid in that same cycle
//   quotient, remainder   results; both 0 when the divisor is 0
//
// Optional feature (macro LC4_ALU_DIV_EARLY_EXIT_EN): when the divisor is 0 or
// dividend < divisor the divider finishes in its first running cycle.
module lc4_div_iter
  import lc4_alu_pkg::*;
#(
  parameter int DIV_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DIV_STEPS) + 1;

  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] quo_reg;   // holds the dividend, shifted out as quotient bits shift in
  logic [DATA_W-1:0] dsr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              run_reg;

  logic [DATA_W:0]   shifted;
  logic              ge;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;
  logic              last;
  logic              dsr_zero;
  logic              early;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // shifted[16] set means the partial remainder already exceeds any 16-bit
  // divisor; the 16-bit difference is still exact because the true
  // difference is below the divisor.
  assign shifted  = {rem_reg, quo_reg[DATA_W-1]};
  assign ge       = shifted[DATA_W] || (shifted[DATA_W-1:0] >= dsr_reg);
  assign rem_step = ge ? (shifted[DATA_W-1:0] - dsr_reg) : shifted[DATA_W-1:0];
  assign quo_step = {quo_reg[DATA_W-2:0], ge};
  assign last     = (cnt_reg == CNT_W'(DIV_STEPS - 1));
  assign dsr_zero = (dsr_reg == '0);

`ifdef LC4_ALU_DIV_EARLY_EXIT_EN
  logic early_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      early_reg <= 1'b0;
    else if (start && !run_reg)
      early_reg <= (divisor == '0) || (dividend < divisor);
  end

  assign early = early_reg;
`else
  assign early = 1'b0;
`endif

  assign done = run_reg && (early || last);

  // A zero divisor yields 0 for both results. On an early exit the dividend
  // is still unshifted in quo_reg and is the remainder.
  assign quotient  = (dsr_zero || early) ? '0 : quo_step;
  assign remainder = dsr_zero ? '0 : (early ? quo_reg : rem_step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dsr_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start && !run_reg) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dsr_reg <= divisor;
      cnt_reg <= '0;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (done) begin
        run_reg <= 1'b0;
      end else begin
        rem_reg <= rem_step;
        quo_reg <= quo_step;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc4_alu_seq.sv
// lc4_alu_seq -- request/response sequencer in front of the shared LC4 ALU,
// adding an iterative divider for DIV (op 3) and MOD (op 4).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake; req_ready = idle
//   req_op, req_a, req_b            control code and operands
//   alu_ctl, alu_a, alu_b           registered drive to the shared ALU, 0 outside EXEC
//   alu_c                           combinational ALU result
//   resp_valid/resp_ready           response handshake, result held until taken
//   resp_data, resp_err             result; resp_err flags an illegal op (data 0)
//   busy                            high whenever not idle
//
// Parameter DIV_STEPS: divide iterations; only 16 is meaningful (16-bit datapath).
// Optional feature (macro LC4_ALU_DIV_EARLY_EXIT_EN): DIV/MOD with a zero
// divisor or dividend < divisor finish after one divider cycle.
module lc4_alu_seq
  import lc4_alu_pkg::*;
#(
  parameter int DIV_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [OP_W-1:0]   alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy
);

  state_e            state_reg, state_next;
  logic [OP_W-1:0]   alu_ctl_reg, alu_ctl_next;
  logic [DATA_W-1:0] alu_a_reg, alu_a_next;
  logic [DATA_W-1:0] alu_b_reg, alu_b_next;
  logic [DATA_W-1:0] resp_data_reg, resp_data_next;
  logic              resp_err_reg, resp_err_next;
  logic              is_mod_reg, is_mod_next;

  logic              req_legal;
  logic              req_is_div;
  logic              div_start;
  logic              div_done;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem;

  assign req_legal  = is_legal_op(req_op);
  assign req_is_div = is_div_op(req_op);

  // Divider loads on the accepting edge so its first step runs in the
  // first DIV cycle.
  assign div_start = (state_reg == ST_IDLE) && req_valid && req_is_div;

  lc4_div_iter #(
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (req_a),
    .divisor   (req_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_next     = state_reg;
    resp_data_next = resp_data_reg;
    resp_err_next  = resp_err_reg;
    is_mod_next    = is_mod_reg;
    // ALU drive is zero except for the single EXEC cycle.
    alu_ctl_next   = '0;
    alu_a_next     = '0;
    alu_b_next     = '0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_legal) begin
            state_next     = ST_DONE;
            resp_data_next = '0;
            resp_err_next  = 1'b1;
          end else if (req_is_div) begin
            state_next    = ST_DIV;
            is_mod_next   = (req_op == OP_MOD);
            resp_err_next = 1'b0;
          end else begin
            state_next    = ST_EXEC;
            alu_ctl_next  = req_op;
            alu_a_next    = req_a;
            alu_b_next    = req_b;
            resp_err_next = 1'b0;
          end
        end
      end
      ST_EXEC: begin
        resp_data_next = alu_c;
        state_next     = ST_DONE;
      end
      ST_DIV: begin
        if (div_done) begin
          resp_data_next = is_mod_reg ? div_rem : div_quo;
          state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        // Return to idle only; a new request waits for the next edge.
        if (resp_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      alu_ctl_reg   <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
      is_mod_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      alu_ctl_reg   <= alu_ctl_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      resp_data_reg <= resp_data_next;
      resp_err_reg  <= resp_err_next;
      is_mod_reg    <= is_mod_next;
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign resp_valid = (state_reg == ST_DONE);
  assign resp_data  = resp_data_reg;
  assign resp_err   = resp_err_reg;
  assign alu_ctl    = alu_ctl_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;

endmodule

// File: tb/tb_lc4_alu_seq.sv
// tb_lc4_alu_seq -- self-checking bench for lc4_alu_seq.
// A transaction-level model (accept -> fixed latency -> held result) is
// compared against the DUT on every falling edge; directed operations also
// check literal result values and response latency.
module tb_lc4_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_c;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

`ifdef LC4_ALU_DIV_EARLY_EXIT_EN
  localparam int LAT_DIV_SHORT = 2;
`else
  localparam int LAT_DIV_SHORT = 17;
`endif

  lc4_alu_seq #(.DIV_STEPS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared single-cycle ALU.
  function automatic logic [15:0] bench_alu(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (c)
      6'd0:    r = a + b;
      6'd1:    r = a * b;
      6'd2:    r = a - b;
      default: r = a ^ b ^ {10'd0, c};
    endcase
    return r;
  endfunction

  assign alu_c = bench_alu(alu_ctl, alu_a, alu_b);

  function automatic bit op_ok(input logic [5:0] op);
    int o;
    o = int'(op);
    return !(o > 39 || o == 8 || (o >= 13 && o <= 15) || (o >= 20 && o <= 23) || (o >= 27 && o <= 31));
  endfunction

  function automatic logic [15:0] exp_result(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    if (!op_ok(op)) return 16'h0;
    if (op == 6'd3) return (b == 0) ? 16'h0 : a / b;
    if (op == 6'd4) return (b == 0) ? 16'h0 : a % b;
    return bench_alu(op, a, b);
  endfunction

  // Cycles from the accepting edge until resp_valid is first seen.
  function automatic int exp_latency(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    if (!op_ok(op)) return 1;
    if (op == 6'd3 || op == 6'd4) begin
`ifdef LC4_ALU_DIV_EARLY_EXIT_EN
      if (b == 0 || a < b) return 2;
`endif
      return 17;
    end
    return 2;
  endfunction

  // Model: phase 0 idle, 1 working (m_rem edges to go), 2 holding result.
  int          m_phase  = 0;
  int          m_rem    = 0;
  logic [15:0] m_data   = '0;
  logic        m_err    = 1'b0;
  bit          m_alu_on = 1'b0;
  logic [5:0]  m_ctl    = '0;
  logic [15:0] m_a      = '0;
  logic [15:0] m_b      = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_rem    <= 0;
      m_data   <= '0;
      m_err    <= 1'b0;
      m_alu_on <= 1'b0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_data   <= exp_result(req_op, req_a, req_b);
          m_err    <= !op_ok(req_op);
          m_rem    <= exp_latency(req_op, req_a, req_b) - 1;
          m_phase  <= (exp_latency(req_op, req_a, req_b) == 1) ? 2 : 1;
          m_alu_on <= op_ok(req_op) && req_op != 6'd3 && req_op != 6'd4;
          m_ctl    <= req_op;
          m_a      <= req_a;
          m_b      <= req_b;
        end
        1: begin
          m_alu_on <= 1'b0;
          m_rem    <= m_rem - 1;
          if (m_rem == 1) m_phase <= 2;
        end
        default: if (resp_ready) m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_phase == 0});
      chk("busy", {31'd0, busy}, {31'd0, m_phase != 0});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_phase == 2});
      chk("alu_ctl", {26'd0, alu_ctl}, {26'd0, m_alu_on ? m_ctl : 6'd0});
      chk("alu_a", {16'd0, alu_a}, {16'd0, m_alu_on ? m_a : 16'd0});
      chk("alu_b", {16'd0, alu_b}, {16'd0, m_alu_on ? m_b : 16'd0});
      if (!rst_n || m_phase == 2) begin
        chk("resp_data", {16'd0, resp_data}, {16'd0, m_data});
        chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
      end
    end
  end

  // Entered and left one time unit after a rising edge.
  task automatic run_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] want_data, input logic want_err, input int want_lat,
                        input int hold, input bit pulse);
    int lat;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) break;
      lat++;
      if (lat > 40) break;
    end
    chk("latency", lat, want_lat);
    chk("data", {16'd0, resp_data}, {16'd0, want_data});
    chk("err", {31'd0, resp_err}, {31'd0, want_err});
    $display("TXN op=%0d a=%h b=%h data=%h err=%0d lat=%0d hold=%0d", op, a, b, resp_data, resp_err, lat, hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (pulse) begin
        req_valid = (i % 2 == 0);
        req_op    = 6'd0;
        req_a     = 16'hBEEF;
        req_b     = 16'h0001;
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op(6'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 2, 0, 0);
    run_op(6'd3, 16'h0064, 16'h0007, 16'h000E, 1'b0, 17, 0, 0);
    run_op(6'd4, 16'h0064, 16'h0007, 16'h0002, 1'b0, 17, 0, 0);
    run_op(6'd3, 16'h1234, 16'h0000, 16'h0000, 1'b0, LAT_DIV_SHORT, 0, 0);
    run_op(6'd4, 16'h1234, 16'h0000, 16'h0000, 1'b0, LAT_DIV_SHORT, 0, 0);
    run_op(6'd4, 16'h0005, 16'h0009, 16'h0005, 1'b0, LAT_DIV_SHORT, 0, 0);
    run_op(6'd3, 16'h0005, 16'h0009, 16'h0000, 1'b0, LAT_DIV_SHORT, 0, 0);
    run_op(6'd4, 16'hFFFF, 16'h0010, 16'h000F, 1'b0, 17, 0, 0);
    run_op(6'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17, 0, 0);
    run_op(6'd3, 16'h0007, 16'h0007, 16'h0001, 1'b0, 17, 0, 0);
    run_op(6'd8, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1, 3, 0);
    run_op(6'd13, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1, 0, 0);
    run_op(6'd40, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1, 0, 0);
    run_op(6'd63, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1, 0, 0);
    run_op(6'd0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 2, 5, 1);
    run_op(6'd1, 16'h0012, 16'h0003, 16'h0036, 1'b0, 2, 0, 0);
    run_op(6'd2, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 2, 0, 0);
    run_op(6'd39, 16'h00F0, 16'h000F, 16'h00D8, 1'b0, 2, 0, 0);

    // Reset in the middle of a divide: abandoned with no response.
    req_op    = 6'd3;
    req_a     = 16'h0064;
    req_b     = 16'h0007;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_data", {16'd0, resp_data}, 32'd0);
    $display("TXN reset during divide step 8 resp_valid=%0d busy=%0d", resp_valid, busy);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(6'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 2, 0, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc4_alu_seq.md
LC4_ALU_SEQ -- requirements
Module: lc4_alu_seq

Interface
REQ-001 SHALL have parameter DIV_STEPS, default 16, the number of iterative divide cycles; legal values are 16 only, since the datapath is 16 bits wide.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: an operation request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have port req_op, input, 6 bits: the ALU control code (same encoding as the ALU output mux, 0..39).
REQ-007 SHALL have ports req_a and req_b, input, 16 bits each: the operands.
REQ-008 SHALL have ports alu_ctl (output, 6 bits), alu_a (output, 16 bits) and alu_b (output, 16 bits): registered controls and operands driven to the shared single-cycle ALU.
REQ-009 SHALL have port alu_c, input, 16 bits: the combinational ALU result.
REQ-010 SHALL have port resp_valid, output, 1 bit: a result is held.
REQ-011 SHALL have port resp_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port resp_data, output, 16 bits: the result.
REQ-013 SHALL have port resp_err, output, 1 bit: illegal op code; resp_data is 0.
REQ-014 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DIV and DONE.
REQ-016 SHALL drive req_ready = (state==IDLE), combinationally from state only.
REQ-017 SHALL accept a request on a rising edge with req_valid&&req_ready, and capture op, a and b.
- op 3 (DIV) or 4 (MOD) -> DIV.
- legal op -> EXEC.
- illegal op (8, 13-15, 20-23, 27-31, >39) -> DONE with resp_err=1 and resp_data=0.
REQ-018 SHALL, in EXEC, hold alu_ctl/alu_a/alu_b stable for exactly one cycle, register alu_c into resp_data at that cycle's end, and go to DONE. Latency: accepted at edge N -> resp_valid high from cycle N+2.
REQ-019 SHALL, in DIV, perform unsigned restoring division, one quotient bit per cycle, MSB first, for DIV_STEPS cycles, then go to DONE.
- resp_data = quotient for op 3; remainder for op 4.
- Latency: resp_valid from cycle N+17.
REQ-020 SHALL, when the divisor is 0, return 0 for both DIV and MOD (LC4 semantics).
REQ-021 SHALL, in DONE, hold resp_valid=1 and keep resp_data/resp_err stable until resp_valid&&resp_ready, then go to IDLE; no new request is accepted in the same cycle.
REQ-022 SHALL drive alu_ctl/alu_a/alu_b = 0 outside EXEC.
REQ-023 SHALL ignore req_valid while not IDLE; requesters hold req_valid until accepted.

Reset
REQ-024 SHALL, on rst_n low, force IDLE and clear the divider registers immediately, abandoning any in-flight operation with no response.
REQ-025 SHALL, during reset, hold these outputs: resp_valid=0, resp_data=0, resp_err=0, alu_ctl=0, alu_a=0, alu_b=0, busy=0, req_ready=1 (state IDLE).
REQ-026 SHALL, after release, accept a request at the first rising edge.

Configuration
REQ-027 SHALL, with LC4_ALU_DIV_EARLY_EXIT_EN defined, complete DIV/MOD in DIV after one cycle when divisor==0 (result 0) or dividend<divisor (quotient 0, remainder=dividend): resp_valid from N+2.
REQ-028 SHALL, without LC4_ALU_DIV_EARLY_EXIT_EN, always spend DIV_STEPS cycles in DIV; results are identical either way.

Structure
REQ-029 SHALL define in package lc4_alu_pkg:
- op-code constants (ADD=0 .. BR=39, DIV=3, MOD=4);
- the FSM state enum;
- an is_legal_op function.
REQ-030 SHALL place the iterative divider datapath (remainder/quotient shift registers, step counter, early-exit detect) in sub-module lc4_div_iter, with start/done handshake; lc4_alu_seq holds the FSM and handshakes.

Verification
REQ-031 SHALL cover: op 0, a=0x0003, b=0x0004, ALU model returns a+b, resp_ready=1 -> resp_valid at N+2, resp_data=0x0007, resp_err=0.
REQ-032 SHALL cover: op 3, a=0x0064, b=0x0007 -> resp_data=0x000E at N+17; repeated with op 4 -> 0x0002; busy=1 and req_ready=0 throughout.
REQ-033 SHALL cover: op 3, b=0 -> resp_data=0 (N+2 with macro, N+17 without); op 4, a=0x0005, b=0x0009 -> 0x0005.
REQ-034 SHALL cover: op 8 -> resp_err=1, resp_data=0 at N+1 DONE; held until resp_ready.
REQ-035 SHALL cover: resp_ready held low 5 cycles after an ADD -> resp_valid/resp_data stable; req_valid pulses ignored; accepted only after the handshake.
REQ-036 SHALL cover: rst_n low at DIV step 8 -> immediate IDLE, resp_valid=0, no response; the next op 0 completes normally.
